zbkb_issue_wb: RTL and testbench

- Front/back-end stage wrapped around the Zbkb bit-manipulation execute unit.
- Front end: accepts raw RV32 instruction words over a valid/ready handshake and decodes the 12 Zbkb instructions to the unit's 4-bit-range op index. Reads operands from an internal 32x32 register file and presents {op, rs1, rs2} to the unit.
- Back end: tracks in-flight instructions for the unit's fixed latency, stalls on RAW hazards, and writes returning results back to the register file.

---
 rtl/zbkb_issue_wb_if.sv | 26 ++
 rtl/zbkb_issue_wb.sv | 107 ++++++++++
 tb/tb_zbkb_issue_wb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/zbkb_issue_wb_if.sv
// zbkb_issue_wb_if: instruction handshake, execute-unit, writeback and debug signals of the Zbkb issue stage
interface zbkb_issue_wb_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] exe_op;
    logic [31:0] exe_rs1;
    logic [31:0] exe_rs2;
    logic [31:0] exe_res;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    modport master (
        output in_valid, in_instr, exe_res, dbg_we, dbg_addr, dbg_wdata,
        input  in_ready, exe_op, exe_rs1, exe_rs2, wb_valid, wb_rd, wb_data, illegal, dbg_rdata
    );
    modport slave (
        input  in_valid, in_instr, exe_res, dbg_we, dbg_addr, dbg_wdata,
        output in_ready, exe_op, exe_rs1, exe_rs2, wb_valid, wb_rd, wb_data, illegal, dbg_rdata
    );
endinterface

// File: rtl/zbkb_issue_wb.sv
// zbkb_issue_wb: decode/issue, RAW hazard tracking and regfile writeback around the Zbkb execute unit
// Define ZBKB_BYPASS_EN to forward exe_res to a source whose only match is the writeback stage.
module zbkb_issue_wb #(
    parameter int LATENCY = 2
) (
    input logic            clk,
    input logic            rst,
    zbkb_issue_wb_if.slave bus
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        is_r, is_i, legal, unary;
    logic [3:0]  op;
    assign {f7, rs2, rs1, f3, rd, opc} = bus.in_instr;
    assign imm = bus.in_instr[31:20];
    assign is_r = opc == 7'b0110011;
    assign is_i = opc == 7'b0010011;
    always_comb begin
        legal = 1'b1;
        op = 4'd0;
        if (is_r && f7 == 7'b0110000 && f3 == 3'b101) op = 4'd0;
        else if (is_r && f7 == 7'b0110000 && f3 == 3'b001) op = 4'd1;
        else if (is_i && imm[11:5] == 7'b0110000 && f3 == 3'b101) op = 4'd2;
        else if (is_r && f7 == 7'b0100000 && f3 == 3'b111) op = 4'd3;
        else if (is_r && f7 == 7'b0100000 && f3 == 3'b110) op = 4'd4;
        else if (is_r && f7 == 7'b0100000 && f3 == 3'b100) op = 4'd5;
        else if (is_r && f7 == 7'b0000100 && f3 == 3'b100) op = 4'd6;
        else if (is_r && f7 == 7'b0000100 && f3 == 3'b111) op = 4'd7;
        else if (is_i && imm == 12'h687 && f3 == 3'b101) op = 4'd8;
        else if (is_i && imm == 12'h698 && f3 == 3'b101) op = 4'd9;
        else if (is_i && imm == 12'h08F && f3 == 3'b001) op = 4'd10;
        else if (is_i && imm == 12'h08F && f3 == 3'b101) op = 4'd11;
        else legal = 1'b0;
    end
    assign unary = op[3];

    logic [31:0]           rf_q [32];
    logic [LATENCY:0]      v_q;
    logic [LATENCY:0][4:0] rd_q;
    logic [LATENCY:0]      hit1, hit2;
    always_comb begin
        for (int i = 0; i <= LATENCY; i++) begin
            hit1[i] = v_q[i] && rs1 != 5'd0 && rd_q[i] == rs1;
            hit2[i] = v_q[i] && is_r && rs2 != 5'd0 && rd_q[i] == rs2;
        end
    end

    logic        hazard;
    logic [31:0] src1, src2;
`ifdef ZBKB_BYPASS_EN
    // The writeback-stage result is already on exe_res, so only younger matches stall.
    assign hazard = bus.in_valid && legal && |(hit1[LATENCY-1:0] | hit2[LATENCY-1:0]);
    assign src1 = hit1[LATENCY] ? bus.exe_res : rf_q[rs1];
    assign src2 = hit2[LATENCY] ? bus.exe_res : rf_q[rs2];
`else
    assign hazard = bus.in_valid && legal && |(hit1 | hit2);
    assign src1 = rf_q[rs1];
    assign src2 = rf_q[rs2];
`endif

    logic        xfer, issue, ill_q;
    logic [3:0]  op_q;
    logic [31:0] rs1_q, rs2_q, rs2_d;
    assign bus.in_ready = !rst && !hazard;
    assign xfer = bus.in_valid && bus.in_ready;
    assign issue = xfer && legal;
    assign rs2_d = unary ? 32'd0 : is_i ? {27'd0, rs2} : src2;
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            rd_q <= '0;
            ill_q <= 1'b0;
            op_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            v_q <= {v_q[LATENCY-1:0], issue};
            rd_q <= {rd_q[LATENCY-1:0], rd};
            ill_q <= xfer && !legal;
            if (issue) begin
                op_q <= op;
                rs1_q <= src1;
                rs2_q <= rs2_d;
            end
        end
    end

    // Writeback beats a same-cycle debug write; x0 stays hard-wired to zero.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (rst || i == 0) rf_q[i] <= '0;
            else if (v_q[LATENCY] && rd_q[LATENCY] == 5'(i)) rf_q[i] <= bus.exe_res;
            else if (bus.dbg_we && bus.dbg_addr == 5'(i)) rf_q[i] <= bus.dbg_wdata;
        end
    end

    assign bus.exe_op = {28'd0, op_q};
    assign bus.exe_rs1 = rs1_q;
    assign bus.exe_rs2 = rs2_q;
    assign bus.wb_valid = v_q[LATENCY];
    assign bus.wb_rd = v_q[LATENCY] ? rd_q[LATENCY] : 5'd0;
    assign bus.wb_data = v_q[LATENCY] ? bus.exe_res : 32'd0;
    assign bus.illegal = ill_q;
    assign bus.dbg_rdata = rf_q[bus.dbg_addr];
endmodule

// File: tb/tb_zbkb_issue_wb.sv
// tb_zbkb_issue_wb: directed and randomized checks of zbkb_issue_wb against an architectural reference model
module tb_zbkb_issue_wb;
    localparam int LAT = 2;
`ifdef ZBKB_BYPASS_EN
    localparam int EXP_STALL = LAT;
`else
    localparam int EXP_STALL = LAT + 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] ref_rf [32];
    logic [36:0] exp_q [$];
    logic [31:0] pipe [LAT];

    zbkb_issue_wb_if bus ();
    zbkb_issue_wb #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] sem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] aa, t;
        logic [31:0] r;
        aa = {a, a};
        r = '0;
        case (op)
            4'd0, 4'd2: begin t = aa >> b[4:0]; r = t[31:0]; end
            4'd1: begin t = aa << b[4:0]; r = t[63:32]; end
            4'd3: r = a & ~b;
            4'd4: r = a | ~b;
            4'd5: r = ~(a ^ b);
            4'd6: r = {b[15:0], a[15:0]};
            4'd7: r = {16'd0, b[7:0], a[7:0]};
            4'd8: for (int i = 0; i < 32; i++) r[i] = a[(i & ~7) + 7 - (i & 7)];
            4'd9: r = {a[7:0], a[15:8], a[23:16], a[31:24]};
            4'd10: for (int i = 0; i < 16; i++) begin r[2*i] = a[i]; r[2*i+1] = a[i+16]; end
            4'd11: for (int i = 0; i < 16; i++) begin r[i] = a[2*i]; r[i+16] = a[2*i+1]; end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Behavioural execute unit: result appears LAT cycles after the operands are presented.
    always @(posedge clk) begin
        pipe[0] <= sem(bus.exe_op[3:0], bus.exe_rs1, bus.exe_rs2);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.exe_res = pipe[LAT-1];

    function automatic int ref_op(input logic [31:0] w);
        casez (w)
            32'b0110000_?????_?????_101_?????_0110011: return 0;
            32'b0110000_?????_?????_001_?????_0110011: return 1;
            32'b0110000_?????_?????_101_?????_0010011: return 2;
            32'b0100000_?????_?????_111_?????_0110011: return 3;
            32'b0100000_?????_?????_110_?????_0110011: return 4;
            32'b0100000_?????_?????_100_?????_0110011: return 5;
            32'b0000100_?????_?????_100_?????_0110011: return 6;
            32'b0000100_?????_?????_111_?????_0110011: return 7;
            32'b011010000111_?????_101_?????_0010011:  return 8;
            32'b011010011000_?????_101_?????_0010011:  return 9;
            32'b000010001111_?????_001_?????_0010011:  return 10;
            32'b000010001111_?????_101_?????_0010011:  return 11;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_op(input int op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        case (op)
            0: return enc_r(7'b0110000, rs2, rs1, 3'b101, rd);
            1: return enc_r(7'b0110000, rs2, rs1, 3'b001, rd);
            2: return enc_i({7'b0110000, rs2}, rs1, 3'b101, rd);
            3: return enc_r(7'b0100000, rs2, rs1, 3'b111, rd);
            4: return enc_r(7'b0100000, rs2, rs1, 3'b110, rd);
            5: return enc_r(7'b0100000, rs2, rs1, 3'b100, rd);
            6: return enc_r(7'b0000100, rs2, rs1, 3'b100, rd);
            7: return enc_r(7'b0000100, rs2, rs1, 3'b111, rd);
            8: return enc_i(12'h687, rs1, 3'b101, rd);
            9: return enc_i(12'h698, rs1, 3'b101, rd);
            10: return enc_i(12'h08F, rs1, 3'b001, rd);
            default: return enc_i(12'h08F, rs1, 3'b101, rd);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [36:0] e;
        @(posedge clk);
        @(negedge clk);
        if (bus.wb_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("wb_unexpected", {31'd0, bus.wb_valid}, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e[36:32]});
                chk("wb_data", bus.wb_data, e[31:0]);
            end
        end
    endtask

    task automatic offer(input logic [31:0] w, output int stalls);
        int op;
        logic [31:0] b, r;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        stalls = 0;
        #1;
        while (bus.in_ready !== 1'b1 && stalls < 50) begin
            tick();
            #1;
            stalls++;
        end
        chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
        op = ref_op(w);
        if (op >= 0) begin
            b = (op == 2) ? {27'd0, w[24:20]} : ref_rf[w[24:20]];
            r = sem(4'(op), ref_rf[w[19:15]], b);
            exp_q.push_back({w[11:7], r});
            if (w[11:7] != 5'd0) ref_rf[w[11:7]] = r;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_instr = $urandom;
    endtask

    task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
        bus.dbg_we = 1'b1;
        bus.dbg_addr = a;
        bus.dbg_wdata = d;
        tick();
        bus.dbg_we = 1'b0;
        if (a != 5'd0) ref_rf[a] = d;
    endtask

    task automatic dbg_chk(input logic [4:0] a);
        bus.dbg_addr = a;
        #1;
        chk($sformatf("dbg_x%0d", a), bus.dbg_rdata, ref_rf[a]);
    endtask

    task automatic drain();
        repeat (LAT + 2) tick();
    endtask

    initial begin
        int s;
        int k;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = '0;
        bus.dbg_wdata = '0;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        chk("rst_exe_op", bus.exe_op, 32'd0);
        for (int i = 0; i < 32; i++) dbg_chk(5'(i));

        dbg_wr(5'd1, 32'h80000001);
        dbg_wr(5'd2, 32'd4);
        offer(32'h6020D1B3, s);
        chk("ror_stall", 32'(s), 32'd0);
        chk("ror_exe_op", bus.exe_op, 32'd0);
        chk("ror_exe_rs1", bus.exe_rs1, 32'h80000001);
        chk("ror_exe_rs2", bus.exe_rs2, 32'd4);
        tick();
        tick();
        chk("ror_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("ror_wb_rd", {27'd0, bus.wb_rd}, 32'd3);
        chk("ror_wb_data", bus.wb_data, 32'h18000000);
        tick();
        bus.dbg_addr = 5'd3;
        #1;
        chk("ror_x3", bus.dbg_rdata, 32'h18000000);

        offer(32'h6080D213, s);
        chk("rori_exe_op", bus.exe_op, 32'd2);
        chk("rori_exe_rs2", bus.exe_rs2, 32'd8);
        drain();
        bus.dbg_addr = 5'd4;
        #1;
        chk("rori_x4", bus.dbg_rdata, 32'h01800000);

        offer(enc_op(3, 5'd5, 5'd1, 5'd2), s);
        offer(enc_op(5, 5'd6, 5'd5, 5'd1), s);
        chk("dep_stall", 32'(s), 32'(EXP_STALL));
        drain();
        bus.dbg_addr = 5'd5;
        #1;
        chk("dep_x5", bus.dbg_rdata, 32'h80000001);
        bus.dbg_addr = 5'd6;
        #1;
        chk("dep_x6", bus.dbg_rdata, 32'hFFFFFFFF);

        offer(enc_op(8, 5'd8, 5'd1, 5'd0), s);
        chk("brev8_exe_op", bus.exe_op, 32'd8);
        chk("brev8_exe_rs2", bus.exe_rs2, 32'd0);
        drain();
        dbg_chk(5'd8);

        offer(32'h00000013, s);
        chk("ill_stall", 32'(s), 32'd0);
        chk("ill_pulse", {31'd0, bus.illegal}, 32'd1);
        chk("ill_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        offer(enc_op(1, 5'd9, 5'd1, 5'd2), s);
        chk("ill_next_stall", 32'(s), 32'd0);
        chk("ill_pulse_end", {31'd0, bus.illegal}, 32'd0);
        chk("ill_next_op", bus.exe_op, 32'd1);
        drain();
        dbg_chk(5'd9);

        offer(enc_op(0, 5'd0, 5'd1, 5'd2), s);
        tick();
        tick();
        chk("x0_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("x0_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
        tick();
        bus.dbg_addr = 5'd0;
        #1;
        chk("x0_read", bus.dbg_rdata, 32'd0);

        offer(enc_op(0, 5'd7, 5'd1, 5'd2), s);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        drain();
        bus.dbg_addr = 5'd7;
        #1;
        chk("midrst_x7", bus.dbg_rdata, 32'd0);
        bus.dbg_addr = 5'd1;
        #1;
        chk("midrst_x1", bus.dbg_rdata, 32'd0);

        for (int i = 1; i < 32; i++) dbg_wr(5'(i), $urandom);
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 15);
            if (k < 12) offer(enc_op(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))), s);
            else if (k < 14) offer($urandom, s);
            else tick();
        end
        drain();
        for (int i = 0; i < 32; i++) dbg_chk(5'(i));
        chk("wb_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
